con_ff_unit: RTL
================

// Module: con_ff_unit
// PURPOSE
//   Parametrised branch-condition unit for the datapath control path. On CON_en it
//     evaluates the IR condition field against Bus_data and registers the result.
//   Holds the result with a valid flag until the control unit consumes it (con_ack)
//     or the pipeline flushes it.
//   Keeps saturating evaluation/taken counters for branch statistics.
// PARAMETERS
//   DATA_W    32  width of Bus_data (two's complement)
//   IR_W      32  width of IR
//   COND_LSB  0   bit position of the condition field LSB within IR
//   COND_W    3   condition field width: 2 = codes 0-3 only, 3 = all eight codes
//   CNT_W     16  width of the statistics counters
// PORTS
//   clk        in   1         rising-edge clock
//   clr        in   1         asynchronous, active-high reset
//   IR         in   IR_W      instruction; condition = IR[COND_LSB+COND_W-1:COND_LSB]
//   Bus_data   in   DATA_W    operand to test, sampled on the clk edge with CON_en
//   CON_en     in   1         capture request (single-cycle strobe)
//   con_ack    in   1         control unit has consumed con_out
//   flush      in   1         discard any held result
//   cnt_clr    in   1         synchronous clear of both counters
//   con_out    out  1         registered branch decision; forced 0 when con_valid=0
//   con_valid  out  1         con_out holds an unconsumed decision
//   eval_cnt   out  CNT_W     number of accepted captures, saturating
//   taken_cnt  out  CNT_W     number of captures whose decision was 1, saturating
// BEHAVIOUR
//   Reset: con_out=0, con_valid=0, eval_cnt=0, taken_cnt=0, FSM=IDLE.
//     Reset is asserted asynchronously and released synchronously to clk.
//   Conditions (Z = Bus_data==0, N = Bus_data[DATA_W-1]):
//     0 eq: Z           1 ne: !Z          2 ge: !N          3 lt: N
//     4 gt: !N & !Z     5 le: N | Z       6 always: 1       7 never: 0
//   COND_W=2: only the 2-bit field is decoded; codes 4-7 cannot occur.
//   FSM states: IDLE (no decision held) and HELD (decision valid).
//     IDLE, CON_en=1 -> HELD. Capture the result; latency is one cycle to con_valid=1.
//     HELD, con_ack=1, CON_en=0 -> IDLE. con_valid=0 and con_out=0 in the next cycle.
//     HELD, CON_en=1 (with or without con_ack) -> stay in HELD.
//       The new result replaces the old one, and it counts as a new capture.
//     HELD, neither input asserted -> hold con_out and con_valid unchanged.
//     con_ack while IDLE is ignored.
//   flush (any state) -> IDLE next cycle. It has priority over CON_en and con_ack;
//     the CON_en in that same cycle is dropped and is not counted.
//   Counters: eval_cnt += 1 on each accepted capture; taken_cnt += 1 when that
//     capture's result is 1.
//     Each counter saturates at 2^CNT_W-1 and does not wrap.
//     cnt_clr has priority over an increment in the same cycle (result 0).
//     cnt_clr does not affect the FSM or con_out.
//   Reset mid-operation: everything returns to reset values immediately.
//     A pending decision is lost.
//   No combinational path from any input to any output; all outputs are registered.
// STRUCTURE
//   Package con_pkg: COND_EQ..COND_NEVER localparams (3-bit codes 0-7) and
//     state encodings ST_IDLE / ST_HELD.
//   Sub-module con_eval (combinational): Bus_data and the condition code in,
//     decision bit out. Parametrised by DATA_W and COND_W.
//   con_ff_unit holds the FSM, the result register and the two counters.
// TESTING
//   1. Code 0, Bus_data=0, CON_en 1 cycle -> next cycle con_valid=1, con_out=1;
//      eval_cnt=1, taken_cnt=1.
//   2. Sweep codes 0-7 with Bus_data in {0, 5, 32'h8000_0000, -1}, ack each one ->
//      con_out matches the table. Check ge/lt at 32'h8000_0000 (lt=1) and at 0 (ge=1, gt=0).
//   3. HELD with con_out=1, then CON_en with code 7 plus con_ack in the same cycle ->
//      next cycle con_valid=1, con_out=0; eval_cnt increments and taken_cnt does not.
//   4. flush+CON_en in the same cycle from IDLE -> con_valid stays 0, counters unchanged;
//      con_ack in IDLE -> no change.
//   5. CNT_W=4, 20 captures of code 6 -> both counters stick at 15;
//      cnt_clr alongside a capture -> both counters read 0.
//   6. clr asserted mid-cycle while HELD -> outputs go to 0 before the next clk edge;
//      after release, first CON_en behaves as in scenario 1.

Source files
------------

// File: rtl/con_pkg.sv
// con_pkg: condition codes and FSM state encoding for the branch-condition unit
package con_pkg;
  localparam logic [2:0] COND_EQ    = 3'd0;
  localparam logic [2:0] COND_NE    = 3'd1;
  localparam logic [2:0] COND_GE    = 3'd2;
  localparam logic [2:0] COND_LT    = 3'd3;
  localparam logic [2:0] COND_GT    = 3'd4;
  localparam logic [2:0] COND_LE    = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER = 3'd7;
  typedef enum logic {ST_IDLE = 1'b0, ST_HELD = 1'b1} state_t;
endpackage

// File: rtl/con_eval.sv
// con_eval: combinational decode of a condition code against a two's complement operand
module con_eval #(
  parameter int DATA_W = 32,
  parameter int COND_W = 3
) (
  input  logic [DATA_W-1:0] data,
  input  logic [COND_W-1:0] cond,
  output logic              taken
);
  import con_pkg::*;
  logic z, n;
  logic [2:0] code;
  logic [7:0] tbl;
  always_comb begin
    z = data == '0;
    n = data[DATA_W-1];
    code = 3'(cond);
    tbl = '0;
    tbl[COND_EQ]     = z;
    tbl[COND_NE]     = !z;
    tbl[COND_GE]     = !n;
    tbl[COND_LT]     = n;
    tbl[COND_GT]     = !n && !z;
    tbl[COND_LE]     = n || z;
    tbl[COND_ALWAYS] = 1'b1;
    tbl[COND_NEVER]  = 1'b0;
    taken = tbl[code];
  end
endmodule

// File: rtl/con_ff_unit.sv
// con_ff_unit: registered branch decision with valid/ack handshake and saturating statistics
module con_ff_unit #(
  parameter int DATA_W   = 32,
  parameter int IR_W     = 32,
  parameter int COND_LSB = 0,
  parameter int COND_W   = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [IR_W-1:0]   IR,
  input  logic [DATA_W-1:0] Bus_data,
  input  logic              CON_en,
  input  logic              con_ack,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              con_out,
  output logic              con_valid,
  output logic [CNT_W-1:0]  eval_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  import con_pkg::*;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic con_out_q, con_out_d;
  logic [CNT_W-1:0] eval_q, eval_d, taken_q, taken_d;
  logic dec, cap;
  logic ir_unused;
  assign ir_unused = ^IR;
  con_eval #(.DATA_W(DATA_W), .COND_W(COND_W)) u_eval (
    .data (Bus_data),
    .cond (IR[COND_LSB +: COND_W]),
    .taken(dec)
  );
  // flush wins over capture and ack; a flushed capture is not counted
  always_comb begin
    cap = CON_en && !flush;
    state_d = flush ? ST_IDLE : CON_en ? ST_HELD : (state_q == ST_HELD && con_ack) ? ST_IDLE : state_q;
    con_out_d = flush ? 1'b0 : CON_en ? dec : con_ack ? 1'b0 : con_out_q;
    eval_d = cnt_clr ? '0 : (cap && eval_q != CNT_MAX) ? eval_q + 1'b1 : eval_q;
    taken_d = cnt_clr ? '0 : (cap && dec && taken_q != CNT_MAX) ? taken_q + 1'b1 : taken_q;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      con_out_q <= 1'b0;
      eval_q    <= '0;
      taken_q   <= '0;
    end else begin
      state_q   <= state_d;
      con_out_q <= con_out_d;
      eval_q    <= eval_d;
      taken_q   <= taken_d;
    end
  end
  assign con_out   = con_out_q;
  assign con_valid = state_q == ST_HELD;
  assign eval_cnt  = eval_q;
  assign taken_cnt = taken_q;
endmodule
